chip8_vga_scanout: RTL and testbench
====================================

Name: chip8_vga_scanout

Overview:
- Downstream consumer of chip8_top's 2048-bit `display` vector; converts it to a raster pixel stream with hsync, vsync and data-enable for a VGA-style sink.
- Each CHIP-8 pixel is scaled by SCALE in both axes and placed in a window inside the active area.
- `display` is snapshotted once per frame at vblank start, so a frame never tears mid-scan.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- SCALE, 10, replication factor per CHIP-8 pixel (64*SCALE <= H_ACTIVE, 32*SCALE <= V_ACTIVE)
- H_OFFSET, 0, first active column of the CHIP-8 window
- V_OFFSET, 80, first active line of the CHIP-8 window

Ports:
- clk, input, 1, pixel clock
- reset, input, 1, asynchronous active-low reset
- display, input, 2048, CHIP-8 framebuffer; pixel (x,y) is at bit 2047-(y*64+x)
- hsync, output, 1, horizontal sync, active-low
- vsync, output, 1, vertical sync, active-low
- de, output, 1, data enable (active area)
- pixel, output, 1, monochrome pixel value
- frame_tick, output, 1, one-cycle pulse when the shadow snapshot is taken

Behaviour:
- Interface: one clock `clk`; `reset` is asynchronous and active-low.
- Counters:
  - hcnt runs 0..H_TOTAL-1, with H_TOTAL = sum of the H_* parameters.
  - vcnt runs 0..V_TOTAL-1 and increments when hcnt wraps.
  - Both wrap to 0; there is no stall condition.
  - Region order per axis: active, front porch, sync, back porch.
- Reset (asserted): hcnt=0, vcnt=0, shadow=0.
  - Outputs: hsync=1, vsync=1, de=0, pixel=0, frame_tick=0.
  - Reset asserted mid-line aborts the line immediately; the count restarts at (0,0) on the first clock edge after release.
- Snapshot: on the cycle where hcnt==0 and vcnt==V_ACTIVE (first front-porch line), the block loads shadow<=display and asserts frame_tick for that cycle.
  - A `display` change during the active area is not visible until the next frame.
  - The first frame after reset shows an all-zero image.
- Window mapping:
  - inwin = hcnt in [H_OFFSET, H_OFFSET+64*SCALE) and vcnt in [V_OFFSET, V_OFFSET+32*SCALE).
  - px = (hcnt-H_OFFSET)/SCALE and py = (vcnt-V_OFFSET)/SCALE.
  - Implement px/py with sub-counters that count 0..SCALE-1 and then increment px/py, not with dividers.
  - px resets at every line start; py resets at vcnt==0.
- Pipeline: all outputs are registered with one cycle of latency from the counter state (hcnt,vcnt).
  - hsync = !(hcnt in sync region).
  - vsync = !(vcnt in sync region).
  - de = hcnt<H_ACTIVE && vcnt<V_ACTIVE.
  - pixel = de && inwin && shadow[2047-(py*64+px)].
  - hsync, vsync, de and pixel remain mutually aligned.
- Outside the window but inside the active area: pixel=0.
- Outside the active area: pixel=0 and de=0.
- Wrap: the last cycle (H_TOTAL-1, V_TOTAL-1) is followed by (0,0) with no extra idle cycle.

Optional Feature:
- Macro: CHIP8_SCANOUT_BORDER_EN.
- Defined: active-area lines V_OFFSET-1 and V_OFFSET+32*SCALE, spanning columns [H_OFFSET, H_OFFSET+64*SCALE), output pixel=1. This frames the window.
  - Lines outside 0..V_ACTIVE-1 are suppressed.
- Undefined: those pixels output 0, and no border logic is present.

Test Plan:
- Reset hold: reset=0 for 5 cycles with display=all ones, then released. Required: hsync=1, vsync=1, de=0, pixel=0 while held; the first frame after release shows pixel=0 everywhere.
- Timing, default params: count clocks between hsync falling edges and lines between vsync falling edges. Required: 800 clocks per line, 525 lines per frame, hsync low for 96 clocks, vsync low for 2 lines.
- Pixel map with SCALE=10: display bit 2047 only (pixel 0,0) set, after one snapshot. Required:
  - pixel=1 exactly for active columns 0..9 on lines 80..89, 100 high clocks per frame.
  - Bit 0 only (pixel 63,31) set gives pixel=1 at columns 630..639 on lines 390..399.
- Tear-free: toggle display from all-zero to all-ones while vcnt=200. Required: the current frame stays all-zero and the next frame shows pixel=1 across the whole 640x320 window. frame_tick pulses exactly once per frame at (0,480).
- Reset mid-frame: assert reset at vcnt=300, hcnt=123 for 3 cycles. Required: outputs return to reset values immediately. After release, the first hsync falls at clock 656+1 and vsync at line 490.
- Border: with CHIP8_SCANOUT_BORDER_EN defined and display=0. Required: pixel=1 for columns 0..639 on lines 79 and 400, and 0 elsewhere. Undefined: pixel=0 everywhere.

Source files
------------

// File: rtl/chip8_vga_scanout.sv
// chip8_vga_scanout: rasterises the 64x32 CHIP-8 framebuffer into a
// VGA-style pixel stream (hsync/vsync/de/pixel), scaling each CHIP-8 pixel
// by SCALE in both axes and placing it in a window inside the active area.
// The framebuffer is snapshotted at the start of vertical blanking, so a
// frame never tears mid-scan.
// Optional build macro CHIP8_SCANOUT_BORDER_EN: draws a one-line border
// directly above and below the CHIP-8 window.
module chip8_vga_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SCALE    = 10,
  parameter int H_OFFSET = 0,
  parameter int V_OFFSET = 80
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [2047:0] display,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic          pixel,
  output logic          frame_tick
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int SW      = (SCALE > 1) ? $clog2(SCALE) : 1;

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_S   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_E   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_WIN_S    = HW'(H_OFFSET);
  localparam logic [HW-1:0] H_WIN_E    = HW'(H_OFFSET + 64 * SCALE);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_S   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_E   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_WIN_S    = VW'(V_OFFSET);
  localparam logic [VW-1:0] V_WIN_E    = VW'(V_OFFSET + 32 * SCALE);
  localparam logic [SW-1:0] SCALE_LAST = SW'(SCALE - 1);

`ifdef CHIP8_SCANOUT_BORDER_EN
  localparam logic          HAS_TOP = (V_OFFSET > 0) && (V_OFFSET - 1 < V_ACTIVE);
  localparam logic          HAS_BOT = (V_OFFSET + 32 * SCALE < V_ACTIVE);
  localparam logic [VW-1:0] V_BTOP  = VW'(V_OFFSET - 1);
  localparam logic [VW-1:0] V_BBOT  = VW'(V_OFFSET + 32 * SCALE);
`endif

  logic [HW-1:0]  hcnt, hn;
  logic [VW-1:0]  vcnt, vn;
  logic           h_wrap, v_wrap;
  logic           h_in, v_in;
  logic [SW-1:0]  hsub, vsub;
  logic [5:0]     px;
  logic [4:0]     py;
  logic [2047:0]  shadow;
  logic           snap;
  logic [10:0]    pix_idx;
  logic           hsync_n, vsync_n, de_n, pixel_n;

  // Next raster position and per-cycle decode of the current position
  always_comb begin
    h_wrap  = (hcnt == H_LAST);
    v_wrap  = (vcnt == V_LAST);
    hn      = h_wrap ? '0 : hcnt + 1'b1;
    vn      = vcnt;
    if (h_wrap) vn = v_wrap ? '0 : vcnt + 1'b1;
    snap    = (hcnt == '0) && (vcnt == V_ACT);
    pix_idx = {py, px};
    hsync_n = !((hcnt >= H_SYNC_S) && (hcnt < H_SYNC_E));
    vsync_n = !((vcnt >= V_SYNC_S) && (vcnt < V_SYNC_E));
    de_n    = (hcnt < H_ACT) && (vcnt < V_ACT);
    // ~pix_idx == 2047 - (py*64 + px): pixel (0,0) lives in the MSB
    pixel_n = de_n && h_in && v_in && shadow[~pix_idx];
`ifdef CHIP8_SCANOUT_BORDER_EN
    if (de_n && h_in && ((HAS_TOP && (vcnt == V_BTOP)) || (HAS_BOT && (vcnt == V_BBOT))))
      pixel_n = 1'b1;
`endif
  end

  // Free-running raster counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hcnt <= '0;
      vcnt <= '0;
    end else begin
      hcnt <= hn;
      vcnt <= vn;
    end
  end

  // Window flags tracked by equality on the next count, so they stay aligned
  // with hcnt/vcnt without magnitude compares against a possibly-zero offset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_in <= (H_OFFSET == 0);
      v_in <= (V_OFFSET == 0);
    end else begin
      h_in <= (hn == H_WIN_S) | (h_in & (hn != H_WIN_E) & (hn != '0));
      if (h_wrap)
        v_in <= (vn == V_WIN_S) | (v_in & (vn != V_WIN_E) & (vn != '0));
    end
  end

  // Horizontal scale sub-counter and CHIP-8 column; cleared at each line start
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hsub <= '0;
      px   <= '0;
    end else if (h_wrap) begin
      hsub <= '0;
      px   <= '0;
    end else if (h_in) begin
      if (hsub == SCALE_LAST) begin
        hsub <= '0;
        px   <= px + 1'b1;
      end else begin
        hsub <= hsub + 1'b1;
      end
    end
  end

  // Vertical scale sub-counter and CHIP-8 row; cleared at the top of frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vsub <= '0;
      py   <= '0;
    end else if (h_wrap) begin
      if (v_wrap) begin
        vsub <= '0;
        py   <= '0;
      end else if (v_in) begin
        if (vsub == SCALE_LAST) begin
          vsub <= '0;
          py   <= py + 1'b1;
        end else begin
          vsub <= vsub + 1'b1;
        end
      end
    end
  end

  // Framebuffer snapshot at the first front-porch line
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) shadow <= '0;
    else if (snap) shadow <= display;
  end

  // Registered outputs, one cycle behind the raster position
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      de         <= 1'b0;
      pixel      <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      hsync      <= hsync_n;
      vsync      <= vsync_n;
      de         <= de_n;
      pixel      <= pixel_n;
      frame_tick <= snap;
    end
  end

endmodule

// File: tb/tb_chip8_vga_scanout.sv
// tb_chip8_vga_scanout: directed bench for chip8_vga_scanout using a reduced
// raster (140x76 total, SCALE=2) so full frames stay short.
module tb_chip8_vga_scanout;

  localparam int HA = 132, HF = 2, HS = 4, HB = 2;
  localparam int VA = 70,  VF = 2, VS = 2, VB = 2;
  localparam int SC = 2, HO = 2, VO = 4;
  localparam int HT = HA + HF + HS + HB;   // 140
  localparam int VT = VA + VF + VS + VB;   // 76
  localparam int FRAME = HT * VT;          // 10640
`ifdef CHIP8_SCANOUT_BORDER_EN
  localparam int BORDER = 2 * 64 * SC;     // two 128-pixel lines
`else
  localparam int BORDER = 0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [2047:0] display = '1;
  logic          hsync, vsync, de, pixel, frame_tick;

  int total = 0;
  int bad   = 0;

  chip8_vga_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SCALE(SC), .H_OFFSET(HO), .V_OFFSET(VO)
  ) dut (
    .clk(clk), .reset(reset), .display(display),
    .hsync(hsync), .vsync(vsync), .de(de), .pixel(pixel), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Raster position tracker: oh/ov is the position whose outputs are visible
  int th, tv, oh, ov;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      th <= 0; tv <= 0; oh <= 0; ov <= 0;
    end else begin
      oh <= th; ov <= tv;
      if (th == HT - 1) begin
        th <= 0;
        tv <= (tv == VT - 1) ? 0 : tv + 1;
      end else begin
        th <= th + 1;
      end
    end
  end

  // Expected {hsync,vsync,de,pixel,frame_tick} at raster position (h,v)
  function automatic logic [4:0] exp_out(input int h, input int v, input logic [2047:0] sh);
    logic d, w, p, hs, vs, t;
    hs = !(h >= HA + HF && h < HA + HF + HS);
    vs = !(v >= VA + VF && v < VA + VF + VS);
    d  = (h < HA) && (v < VA);
    w  = (h >= HO) && (h < HO + 64 * SC) && (v >= VO) && (v < VO + 32 * SC);
    p  = 1'b0;
    if (d && w) p = sh[2047 - (((v - VO) / SC) * 64 + (h - HO) / SC)];
`ifdef CHIP8_SCANOUT_BORDER_EN
    if (d && h >= HO && h < HO + 64 * SC && (v == VO - 1 || v == VO + 32 * SC)) p = 1'b1;
`endif
    t  = (h == 0) && (v == VA);
    return {hs, vs, d, p, t};
  endfunction

  // Stream statistics gathered by run()
  int ecount;
  int c_pix, c_mis, c_de, c_hfall, c_hlow, c_vfall, c_vlow, c_tick, c_hper_bad;
  int first_hf, first_vf, last_hf, fp_h, fp_v, mis_h, mis_v;
  logic prev_hs, prev_vs;
  logic [4:0] mis_act, mis_exp;

  task automatic clear_stats();
    c_pix = 0; c_mis = 0; c_de = 0; c_hfall = 0; c_hlow = 0;
    c_vfall = 0; c_vlow = 0; c_tick = 0; c_hper_bad = 0;
    first_hf = -1; first_vf = -1; last_hf = -1; fp_h = -1; fp_v = -1;
    mis_h = -1; mis_v = -1; mis_act = '0; mis_exp = '0;
    prev_hs = hsync; prev_vs = vsync;
  endtask

  task automatic run(input int n, input logic [2047:0] sh);
    logic [4:0] act, e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      ecount++;
      act = {hsync, vsync, de, pixel, frame_tick};
      e   = exp_out(oh, ov, sh);
      if (act !== e) begin
        if (c_mis == 0) begin mis_h = oh; mis_v = ov; mis_act = act; mis_exp = e; end
        c_mis++;
      end
      if (pixel === 1'b1) begin
        c_pix++;
        if (fp_h < 0 && ov != VO - 1 && ov != VO + 32 * SC) begin fp_h = oh; fp_v = ov; end
      end
      if (de === 1'b1) c_de++;
      if (frame_tick === 1'b1) c_tick++;
      if (hsync === 1'b0) c_hlow++;
      if (vsync === 1'b0) c_vlow++;
      if (prev_hs === 1'b1 && hsync === 1'b0) begin
        c_hfall++;
        if (first_hf < 0) first_hf = ecount;
        if (last_hf >= 0 && ecount - last_hf != HT) c_hper_bad++;
        last_hf = ecount;
      end
      if (prev_vs === 1'b1 && vsync === 1'b0) begin
        c_vfall++;
        if (first_vf < 0) first_vf = ecount;
      end
      prev_hs = hsync; prev_vs = vsync;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    display = '1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if ({hsync, vsync, de, pixel, frame_tick} !== 5'b11000) begin
        bad++;
        $display("FAIL reset_hold[%0d]: got %b want 11000", i, {hsync, vsync, de, pixel, frame_tick});
      end
    end
    @(negedge clk);
    reset = 1'b1;
    ecount = 0;
    display = '0;
    display[2047] = 1'b1;   // picked up by the first snapshot, shown in frame 1
  endtask

  task automatic test_first_frame();
    clear_stats();
    run(FRAME, '0);
    total++;
    if (c_pix !== BORDER) begin bad++; $display("FAIL frame0_pixels: got %0d want %0d", c_pix, BORDER); end
    total++;
    if (c_mis !== 0) begin
      bad++;
      $display("FAIL frame0_stream: mismatches=%0d first h=%0d v=%0d got %b want %b",
               c_mis, mis_h, mis_v, mis_act, mis_exp);
    end
    total++;
    if (c_de !== HA * VA) begin bad++; $display("FAIL frame0_de: got %0d want %0d", c_de, HA * VA); end
  endtask

  // Uses the statistics of the frame just scanned by test_first_frame
  task automatic test_timing();
    total++;
    if (first_hf !== HA + HF + 1) begin bad++; $display("FAIL first_hsync_fall: got %0d want %0d", first_hf, HA + HF + 1); end
    total++;
    if (c_hfall !== VT) begin bad++; $display("FAIL hsync_falls: got %0d want %0d", c_hfall, VT); end
    total++;
    if (c_hper_bad !== 0) begin bad++; $display("FAIL line_period: bad intervals %0d want 0", c_hper_bad); end
    total++;
    if (c_hlow !== VT * HS) begin bad++; $display("FAIL hsync_low: got %0d want %0d", c_hlow, VT * HS); end
    total++;
    if (c_vfall !== 1) begin bad++; $display("FAIL vsync_falls: got %0d want 1", c_vfall); end
    total++;
    if (first_vf !== (VA + VF) * HT + 1) begin bad++; $display("FAIL first_vsync_fall: got %0d want %0d", first_vf, (VA + VF) * HT + 1); end
    total++;
    if (c_vlow !== VS * HT) begin bad++; $display("FAIL vsync_low: got %0d want %0d", c_vlow, VS * HT); end
    total++;
    if (c_tick !== 1) begin bad++; $display("FAIL frame_tick_count: got %0d want 1", c_tick); end
  endtask

  task automatic test_pixel_map();
    logic [2047:0] img;
    // frame 1: only CHIP-8 pixel (0,0) -> columns 2..3, lines 4..5
    img = '0; img[2047] = 1'b1;
    display = '0; display[0] = 1'b1;
    clear_stats();
    run(FRAME, img);
    total++;
    if (c_pix !== 4 + BORDER) begin bad++; $display("FAIL map00_count: got %0d want %0d", c_pix, 4 + BORDER); end
    total++;
    if (fp_h !== 2 || fp_v !== 4) begin bad++; $display("FAIL map00_pos: got (%0d,%0d) want (2,4)", fp_h, fp_v); end
    total++;
    if (c_mis !== 0) begin
      bad++;
      $display("FAIL map00_stream: mismatches=%0d first h=%0d v=%0d got %b want %b", c_mis, mis_h, mis_v, mis_act, mis_exp);
    end
    // frame 2: only CHIP-8 pixel (63,31) -> columns 128..129, lines 66..67
    img = '0; img[0] = 1'b1;
    display = '0;
    clear_stats();
    run(FRAME, img);
    total++;
    if (c_pix !== 4 + BORDER) begin bad++; $display("FAIL map6331_count: got %0d want %0d", c_pix, 4 + BORDER); end
    total++;
    if (fp_h !== 128 || fp_v !== 66) begin bad++; $display("FAIL map6331_pos: got (%0d,%0d) want (128,66)", fp_h, fp_v); end
    total++;
    if (c_mis !== 0) begin
      bad++;
      $display("FAIL map6331_stream: mismatches=%0d first h=%0d v=%0d got %b want %b", c_mis, mis_h, mis_v, mis_act, mis_exp);
    end
  endtask

  task automatic test_tear_free();
    // frame 3: shadow is zero; display flips to ones mid-window
    clear_stats();
    run(30 * HT, '0);
    display = '1;
    run(FRAME - 30 * HT, '0);
    total++;
    if (c_pix !== BORDER) begin bad++; $display("FAIL tear_current_pixels: got %0d want %0d", c_pix, BORDER); end
    total++;
    if (c_mis !== 0) begin
      bad++;
      $display("FAIL tear_current_stream: mismatches=%0d first h=%0d v=%0d got %b want %b", c_mis, mis_h, mis_v, mis_act, mis_exp);
    end
    total++;
    if (c_tick !== 1) begin bad++; $display("FAIL tear_tick_a: got %0d want 1", c_tick); end
    // frame 4: full window lit
    clear_stats();
    run(FRAME, '1);
    total++;
    if (c_pix !== 128 * 64 + BORDER) begin bad++; $display("FAIL tear_next_pixels: got %0d want %0d", c_pix, 128 * 64 + BORDER); end
    total++;
    if (c_mis !== 0) begin
      bad++;
      $display("FAIL tear_next_stream: mismatches=%0d first h=%0d v=%0d got %b want %b", c_mis, mis_h, mis_v, mis_act, mis_exp);
    end
    total++;
    if (c_tick !== 1) begin bad++; $display("FAIL tear_tick_b: got %0d want 1", c_tick); end
  endtask

  task automatic test_reset_mid();
    clear_stats();
    run(40 * HT + 17, '1);   // now sitting at (17,40), inside the lit window
    reset = 1'b0;
    #1;
    total++;
    if ({hsync, vsync, de, pixel, frame_tick} !== 5'b11000) begin
      bad++;
      $display("FAIL reset_mid_immediate: got %b want 11000", {hsync, vsync, de, pixel, frame_tick});
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++;
      if ({hsync, vsync, de, pixel, frame_tick} !== 5'b11000) begin
        bad++;
        $display("FAIL reset_mid_hold[%0d]: got %b want 11000", i, {hsync, vsync, de, pixel, frame_tick});
      end
    end
    @(negedge clk);
    reset = 1'b1;
    ecount = 0;
    clear_stats();
    run(FRAME, '0);          // shadow cleared by reset
    total++;
    if (first_hf !== HA + HF + 1) begin bad++; $display("FAIL reset_mid_hsync: got %0d want %0d", first_hf, HA + HF + 1); end
    total++;
    if (first_vf < 1 || (first_vf - 1) / HT !== VA + VF) begin
      bad++;
      $display("FAIL reset_mid_vsync_line: got edge %0d want line %0d", first_vf, VA + VF);
    end
    total++;
    if (c_pix !== BORDER) begin bad++; $display("FAIL reset_mid_pixels: got %0d want %0d", c_pix, BORDER); end
    total++;
    if (c_mis !== 0) begin
      bad++;
      $display("FAIL reset_mid_stream: mismatches=%0d first h=%0d v=%0d got %b want %b", c_mis, mis_h, mis_v, mis_act, mis_exp);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_first_frame();
    test_timing();
    test_pixel_map();
    test_tear_free();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
